// File: rtl/hw_trace_fifo.sv
// hw_trace_fifo: show-ahead trace capture FIFO with sticky overflow and saturating drop counter
module hw_trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_enable,
  input  logic [ADDR_W-1:0]          in_address,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       capture_en,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_address,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [ADDR_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop, full, wr, drop;
  always_comb begin
    push = in_enable & capture_en;
    out_valid = count != '0;
    pop = out_valid & out_ready;
    full = count == FULL;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    wr = push & (~full | pop);
    drop = push & full & ~pop;
    out_address = mem_a[rp];
    out_data = mem_d[rp];
  end
  always_ff @(posedge clk) begin
    if (wr && !clear && rst_n) begin
      mem_a[wp] <= in_address;
      mem_d[wp] <= in_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (wr && !pop) count <= count + CW'(1);
      else if (pop && !wr) count <= count - CW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/hw_trace_fifo.md
HW_TRACE_FIFO -- requirements
Module: hw_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of trace entries; SHALL be a power of two, 2..256.
REQ-002 Parameter ADDR_W, default 64, width of the captured address field.
REQ-003 Parameter DATA_W, default 32, width of the captured data field.
REQ-004 Parameter CNT_W, default 16, width of the dropped-event counter.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low; the ports are named clk and rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_enable  input  1  hidden-wire event strobe; one event per cycle while high.
REQ-009 in_address  input  ADDR_W  hidden-wire address field, sampled when in_enable is high.
REQ-010 in_data  input  DATA_W  hidden-wire data field, sampled when in_enable is high.
REQ-011 capture_en  input  1  gate; events arriving while low SHALL be ignored and SHALL NOT be counted.
REQ-012 clear  input  1  synchronous flush of the FIFO and all status.
REQ-013 out_valid  output  1  head entry available.
REQ-014 out_ready  input  1  consumer accepts the head entry.
REQ-015 out_address  output  ADDR_W  address field of the head entry.
REQ-016 out_data  output  DATA_W  data field of the head entry.
REQ-017 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-018 overflow  output  1  sticky flag; at least one event dropped since the last reset or clear.
REQ-019 drop_count  output  CNT_W  number of dropped events, saturating.

Function
REQ-020 push SHALL be in_enable & capture_en; pop SHALL be out_valid & out_ready.
REQ-021 The storage SHALL be a circular buffer with write and read pointers that wrap from DEPTH-1 to 0.
REQ-022 A push accepted at rising edge N SHALL make that entry visible on out_* in the cycle after edge N (one-cycle latency, show-ahead).
REQ-023 out_valid SHALL equal (count != 0); out_address and out_data SHALL reflect the entry at the read pointer.
REQ-024 When out_valid is low, out_address and out_data are don't-care.
REQ-025 Entries SHALL leave the FIFO in arrival order, with no duplication or loss of accepted entries.
REQ-026 push without pop, not full: store the entry, advance the write pointer, and increment count.
REQ-027 pop without push: advance the read pointer and decrement count.
REQ-028 push with pop, count between 1 and DEPTH: store and retire in the same cycle; count is unchanged.
REQ-029 push with pop at count==DEPTH: the push SHALL be accepted because the pop frees a slot; nothing is dropped.
REQ-030 push without pop at count==DEPTH: drop the event, set overflow, and increment drop_count; count and pointers are unchanged.
REQ-031 drop_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-032 push at count==0: the entry SHALL NOT bypass to the outputs combinationally; out_valid rises the next cycle.
REQ-033 While out_valid is high and out_ready is low, out_address and out_data SHALL remain stable.
REQ-034 clear SHALL have priority over push and pop in the same cycle: set count=0, both pointers=0, overflow=0, drop_count=0, and discard the concurrent push.
REQ-035 Storage contents need no reset; only pointers, count and status are reset.

Reset
REQ-036 Asserting rst_n low SHALL immediately force count=0, pointers=0, out_valid=0, overflow=0 and drop_count=0, independent of clk.
REQ-037 Reset mid-operation SHALL discard all stored entries; the first push after deassertion SHALL appear as the head entry.
REQ-038 Events presented while rst_n is low SHALL be ignored.

Verification
REQ-039 Reset, then one push (addr=0x0000_0000_8000_0000, data=0xDEADBEEF) with out_ready=0 -> the next cycle shows out_valid=1 with those values, count=1, and stable outputs for 5 cycles.
REQ-040 DEPTH=8, out_ready=0, 10 consecutive pushes (data=1..10) -> count=8, overflow=1, drop_count=2; draining yields data 1..8 in order.
REQ-041 Full FIFO with push and pop in the same cycle (data=0x55) -> count stays 8, drop_count unchanged, and 0x55 is drained last.
REQ-042 Push with capture_en=0 -> no entry stored and drop_count unchanged; push and clear in the same cycle -> count=0, overflow=0.
REQ-043 Stream 20 events with out_ready=1 continuously -> count stays at or below 1, all 20 are received in order, and the pointers wrap twice without loss.
REQ-044 With 3 entries stored, assert rst_n low between clock edges -> out_valid=0 immediately; after release, push 0x77 -> head data=0x77.
